// File: rtl/conv_8_32_pkg.sv
// Shared widths, default idle timeout and FSM encoding for the 8->32 byte packer.
package conv_8_32_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W = 2;
  localparam int TIMEOUT_CYC_DEFAULT = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;
endpackage

// File: rtl/conv_byte_cnt.sv
// 2-bit wrapping byte counter; last flags the byte that completes the current word.
module conv_byte_cnt
  import conv_8_32_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  assign last = inc && (count == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/conv_8_32.sv
// Packs four accepted bytes into a 32-bit word, first byte in the MSBs.
// Optional partial-word idle timeout when CONV_8_32_TIMEOUT_EN is defined.
module conv_8_32
  import conv_8_32_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [BYTE_W-1:0] entrada,
  output logic              valid_out,
  output logic [WORD_W-1:0] salida,
  output logic              drop
);

  // Handshake: a byte is taken on every posedge with valid_in=1; there is no
  // ready, the source never stalls. valid_out is a one-cycle pulse per word and
  // salida holds the last completed word until the next one is assembled.

  state_t state;
  state_t state_next;
  logic [CNT_W-1:0] count;
  logic last;
  logic timeout;
  logic [BYTES_PER_WORD-2:0][BYTE_W-1:0] held;

  conv_byte_cnt u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (valid_in),
    .clear (timeout),
    .count (count),
    .last  (last)
  );

`ifdef CONV_8_32_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle_cnt;

  // Fires on the idle edge that brings the consecutive-idle run to TIMEOUT_CYC.
  assign timeout = (state == COLLECT) && !valid_in &&
                   (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
      drop     <= 1'b0;
    end else begin
      drop <= timeout;
      if (valid_in || (state == IDLE) || timeout) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign drop    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (valid_in) begin
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (timeout || last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Partial bytes live only in held; salida is written solely on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held      <= '0;
      salida    <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= last;
      if (timeout) begin
        held <= '0;
      end else if (last) begin
        salida <= {held[0], held[1], held[2], entrada};
        held   <= '0;
      end else if (valid_in) begin
        held[count] <= entrada;
      end
    end
  end

endmodule

// File: tb/tb_conv_8_32.sv
// Self-checking bench for conv_8_32: directed scenarios plus random byte streams
// compared against a byte-queue reference model.
module tb_conv_8_32;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in = 1'b0;
  logic [7:0]  entrada = 8'h00;
  logic        valid_out;
  logic [31:0] salida;
  logic        drop;

  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  logic [7:0]  m_bytes[$];
  logic [31:0] exp_q[$];
  logic [31:0] m_word = 32'h0;
  logic        m_valid = 1'b0;
  logic        m_drop = 1'b0;
`ifdef CONV_8_32_TIMEOUT_EN
  int m_idle = 0;
`endif

  conv_8_32 #(.TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .entrada   (entrada),
    .valid_out (valid_out),
    .salida    (salida),
    .drop      (drop)
  );

  // clock / reset block
  initial forever #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_bytes.delete();
    exp_q.delete();
    m_word  = 32'h0;
    m_valid = 1'b0;
    m_drop  = 1'b0;
`ifdef CONV_8_32_TIMEOUT_EN
    m_idle = 0;
`endif
  endtask

  // Drive one cycle, advance the model by one edge, compare after the edge.
  task automatic step(input bit v, input logic [7:0] b);
    valid_in = v;
    entrada  = b;
    @(posedge clk);
    #1;
    m_valid = 1'b0;
    m_drop  = 1'b0;
    if (v) begin
      m_bytes.push_back(b);
`ifdef CONV_8_32_TIMEOUT_EN
      m_idle = 0;
`endif
      if (m_bytes.size() == 4) begin
        m_word = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
        exp_q.push_back(m_word);
        m_valid = 1'b1;
        m_bytes.delete();
      end
    end else if (m_bytes.size() > 0) begin
`ifdef CONV_8_32_TIMEOUT_EN
      m_idle++;
      if (m_idle == TO) begin
        m_drop = 1'b1;
        m_bytes.delete();
        m_idle = 0;
      end
`endif
    end
    check("valid_out", 32'(valid_out), 32'(m_valid));
    check("drop", 32'(drop), 32'(m_drop));
    if (valid_out && exp_q.size() > 0) begin
      check("word", salida, exp_q.pop_front());
    end
    check("salida_hold", salida, m_word);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    check("rst_valid_out", 32'(valid_out), 32'h0);
    check("rst_salida", salida, 32'h0);
    check("rst_drop", 32'(drop), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic send4(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      step(1'b1, w[i*8 +: 8]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 8'h00);
    end
  endtask

  initial begin
    // power-on reset, checked before any clock edge
    #1;
    reset = 1'b1;
    #1;
    check("por_valid_out", 32'(valid_out), 32'h0);
    check("por_salida", salida, 32'h0);
    check("por_drop", 32'(drop), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();

    // all-ones word, single pulse
    send4(32'hFFFFFFFF);
    check("ff_word", salida, 32'hFFFFFFFF);
    idle(2);

    // back-to-back words, pulses 4 cycles apart
    send4(32'hDDDDDDDD);
    check("dd_word", salida, 32'hDDDDDDDD);
    send4(32'h00000003);
    check("b2b_word", salida, 32'h00000003);
    idle(1);

    // gap mid-word
    step(1'b1, 8'h12);
    step(1'b1, 8'h34);
    idle(2);
    step(1'b1, 8'h56);
    step(1'b1, 8'h78);
    check("gap_word", salida, 32'h12345678);
    idle(1);

    // reset mid-word discards partial data
    step(1'b1, 8'hAA);
    step(1'b1, 8'hBB);
    do_reset();
    send4(32'h01020304);
    check("post_rst_word", salida, 32'h01020304);
    idle(1);

    // partial word followed by a long idle run
    step(1'b1, 8'hAA);
    step(1'b1, 8'hBB);
    idle(4);
`ifdef CONV_8_32_TIMEOUT_EN
    check("to_salida_kept", salida, 32'h01020304);
    send4(32'h01020304);
    check("to_word", salida, 32'h01020304);
`else
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    check("held_word", salida, 32'hAABB0102);
`endif
    idle(1);

    // random streams with varying density and occasional resets
    for (int seg = 0; seg < 40; seg++) begin
      int dens;
      dens = $urandom_range(30, 100);
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 299) == 0) begin
          do_reset();
        end else begin
          step($urandom_range(1, 100) <= dens, 8'($urandom_range(0, 255)));
        end
      end
    end

    check("exp_q_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_8_32.md
CONV_8_32 -- requirements
Module: conv_8_32

Interface
REQ-001 Parameter TIMEOUT_CYC, default 4: consecutive idle cycles mid-word before a partial word is discarded (used only under REQ-030).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 valid_in  input  1  entrada carries a valid byte this cycle.
REQ-005 entrada  input  8  input byte.
REQ-006 valid_out  output  1  salida holds a newly assembled word; one-cycle pulse per word.
REQ-007 salida  output  32  assembled word; MSB byte = first byte received.
REQ-008 drop  output  1  one-cycle pulse when a partial word is discarded; tied 0 when the REQ-030 feature is compiled out.

Function
REQ-009 The block SHALL pack four accepted bytes into one 32-bit word, the first byte in salida[31:24] and the fourth in salida[7:0].
REQ-010 A byte SHALL be accepted on any posedge clk where valid_in=1; no backpressure exists.
REQ-011 A 2-bit byte counter SHALL increment per accepted byte and wrap 3->0 on the fourth byte.
REQ-012 FSM states: IDLE (count 0, no partial data) and COLLECT (1-3 bytes held).
REQ-013 Transitions: IDLE->COLLECT on an accepted byte; COLLECT->COLLECT on bytes 2-3; COLLECT->IDLE on byte 4, on timeout (REQ-030), or on reset.
REQ-014 When byte 4 is accepted at edge N, salida SHALL update and valid_out SHALL be 1 in the cycle following edge N (one-cycle latency), and valid_out SHALL return to 0 at edge N+1 unless another word completes there.
REQ-015 salida SHALL hold its last word between completions; partial bytes SHALL never appear on salida.
REQ-016 valid_in=0 cycles between bytes SHALL NOT advance the counter or corrupt held bytes (gaps tolerated).
REQ-017 Back-to-back words (valid_in held 1 for 8 cycles) SHALL produce valid_out pulses exactly 4 cycles apart with no lost byte.
REQ-018 A byte accepted in the same cycle valid_out is high SHALL start the next word in the same cycle.

Reset
REQ-019 While reset=1, regardless of clk: valid_out=0, salida=32'h00000000, drop=0, counter=0, FSM=IDLE, held bytes cleared.
REQ-020 Reset asserted mid-word SHALL discard the partial word without a drop pulse.
REQ-021 The first posedge clk after reset deasserts SHALL be able to accept a byte.

Configuration
REQ-030 With CONV_8_32_TIMEOUT_EN defined: in COLLECT, an idle counter SHALL count consecutive valid_in=0 cycles; on reaching TIMEOUT_CYC the partial word is discarded, FSM->IDLE, drop pulses 1 for one cycle, salida unchanged; any accepted byte clears the idle counter.
REQ-031 Without CONV_8_32_TIMEOUT_EN: no idle counter is built, partial words are held indefinitely, drop is constant 0.

Structure
REQ-040 Shared package conv_8_32_pkg SHALL hold BYTE_W=8, WORD_W=32, BYTES_PER_WORD=4, default TIMEOUT_CYC, and the IDLE/COLLECT state encoding.
REQ-041 One sub-module, conv_byte_cnt (2-bit wrapping byte counter with last-byte flag), is natural; packing register and FSM stay in conv_8_32.

Verification
REQ-050 Bytes FF,FF,FF,FF with valid_in=1 on 4 consecutive edges -> salida=32'hFFFFFFFF, valid_out=1 for exactly one cycle after the 4th edge.
REQ-051 Bytes DD,DD,DD,DD then 00,00,00,03 back-to-back -> salida 32'hDDDDDDDD then 32'h00000003, valid_out pulses 4 cycles apart.
REQ-052 Bytes 12,34 then valid_in=0 for 2 cycles then 56,78 -> salida=32'h12345678, single valid_out pulse, drop=0.
REQ-053 Bytes AA,BB then reset pulse then 01,02,03,04 -> salida=32'h01020304, no word containing AA/BB, drop=0.
REQ-054 CONV_8_32_TIMEOUT_EN defined, TIMEOUT_CYC=4: bytes AA,BB then 4 idle cycles -> drop=1 for one cycle, valid_out=0, salida unchanged; then 01,02,03,04 -> 32'h01020304.
REQ-055 Macro undefined, same stimulus as REQ-054 -> drop stays 0; following 01,02 -> salida=32'hAABB0102.
